// File: rtl/message_schedule_stream.sv
// SHA-256 message scheduler: loads one 16-word block, then streams W0..W63 one word per handshake.
// A 16-word sliding window and a single sigma/adder tree produce each W(t+16).
module message_schedule_stream (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [5:0]  out_t,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t      state, state_nxt;
    logic [31:0] win [16];
    logic [3:0]  cnt;
    logic [5:0]  t;
    logic        done_q;
    logic        accept, fire;
    logic [31:0] w_next;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // All handshake-facing outputs decode from state or registers only.
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == STREAM);
    assign busy      = (state != IDLE);
    assign out_data  = win[0];
    assign out_t     = t;
    assign done      = done_q;

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;
    assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (accept && cnt == 4'd15) state_nxt = STREAM;
            STREAM:  if (fire && t == 6'd63) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
            cnt    <= '0;
            t      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fire && (t == 6'd63);
            case (state)
                IDLE: begin
                    if (start) cnt <= '0;
                end
                LOAD: begin
                    if (accept) begin
                        win[cnt] <= in_data;
                        cnt      <= cnt + 4'd1;
                        if (cnt == 4'd15) t <= '0;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                        win[15] <= w_next;
                        t       <= t + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/message_schedule_stream.md
# message_schedule_stream

Sequential SHA-256 message scheduler. Accepts the sixteen 32-bit words of one 512-bit block over a valid/ready input stream, then emits the full schedule W0..W63 one word per handshake to the compression-round datapath. Uses a 16-word sliding window instead of a 64-entry array. It is the producer side of the per-round W_t interface that the round logic consumes.

## Interface
- No parameters: word width is fixed at 32, round count at 64.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a block; honoured only in IDLE
- in_valid  input  1  in_data holds a message word
- in_data  input  32  message word, W0 first, big-endian word order as padded
- in_ready  output  1  scheduler accepts a message word this cycle
- out_valid  output  1  out_data/out_t hold schedule word W_t
- out_data  output  32  W_t
- out_t  output  6  round index t of out_data
- out_ready  input  1  round logic consumes W_t this cycle
- busy  output  1  high in LOAD or STREAM
- done  output  1  one-cycle pulse after W63 is consumed

## Operation
- Window registers win[0..15]; win[0] is the oldest word. Load counter cnt[3:0]. Round counter t[5:0].
- IDLE: in_ready=0, out_valid=0, busy=0. start=1 -> LOAD, cnt=0. in_valid is ignored in IDLE.
- LOAD: in_ready=1. On in_valid&in_ready, win[cnt]<=in_data and cnt increments. The accept with cnt=15 -> STREAM, t=0.
- STREAM: out_valid=1, out_data=win[0], out_t=t. On out_valid&out_ready:
  - shift win[i]<=win[i+1] for i=0..14;
  - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], which equals W(t+16);
  - t increments.
- The handshake with t=63 -> IDLE, done=1 next cycle. The final shift and new win[15] value are don't-care.
- σ0(x) = ror(x,7) ^ ror(x,18) ^ (x>>3).
- σ1(x) = ror(x,17) ^ ror(x,19) ^ (x>>10).
- ror is a 32-bit rotate right; >> is a logical shift.
- The sum is modulo 2^32; carries out of bit 31 are discarded.
- Exactly one adder tree (σ0, σ1, three 32-bit adds) feeds win[15]. There is no 64-word storage.
- start is ignored in LOAD and STREAM.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system): state=IDLE, in_ready=0, out_valid=0, out_data=0, out_t=0, busy=0, done=0, win[*]=0, cnt=0, t=0.
- Reset asserted mid-LOAD or mid-STREAM aborts the block immediately. Outputs take their reset values, and no done pulse is produced.
- start sampled at edge k -> in_ready=1 from cycle k+1.
- The 16th input accept at edge k -> out_valid=1 with W0 from cycle k+1. There is no bubble.
- Throughput is 1 word/cycle in both LOAD and STREAM. Minimum start-to-done is 1+16+64 cycles.
- out_data and out_t stay stable while out_valid=1 and out_ready=0. Backpressure may last any number of cycles.
- in_valid low in LOAD stalls cnt; the window is untouched.
- done asserts the cycle after the W63 handshake, for exactly one cycle, coincident with return to IDLE (busy=0).
- start asserted in the done cycle is honoured: IDLE -> LOAD on that edge.
- All outputs are registered or decoded from state only. There is no combinational path from out_ready or in_valid to any output.

## Test plan
- **"abc" block, no stalls.** Load 0x61626380, 14×0x00000000, 0x00000018. Required:
  - out_t=0..15 echo the inputs;
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405;
  - all 64 words match the software model;
  - done pulses once, 81 cycles after start.
- **Random backpressure.** Toggle out_ready randomly (~50%) over the "abc" block. Required: identical word sequence; out_data and out_t hold steady across every stall.
- **Input gaps.** Drop in_valid for 3 cycles after the 5th and 15th words. Required: cnt holds during gaps; W0..W63 are unchanged from the no-gap run.
- **Wrap/overflow arithmetic.** Load all 16 words = 0xFFFFFFFF. Required: W16 = σ1(0xFFFFFFFF)+0xFFFFFFFF+σ0(0xFFFFFFFF)+0xFFFFFFFF mod 2^32, matching the model. No carry escapes 32 bits.
- **Ignored start.** Pulse start mid-LOAD (after word 7) and mid-STREAM (t=30). Required: no restart, cnt and t sequences unbroken. Start in the done cycle immediately begins a new LOAD.
- **Reset mid-operation.** Assert reset_n=0 at t=40 with out_ready low. Required: out_valid, busy and in_ready drop immediately; no done. A subsequent start and "abc" load reproduce the correct W0..W63.
